// File: rtl/vga_pkg.sv
// Shared widths, default 800x600@60 timing and the optional test-pattern colour table
// for the VGA timing chain.
package vga_pkg;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 11;
    localparam int unsigned RGB_W    = 12;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 23;

    localparam int unsigned TP_BARS = 8;

    // Vertical bar colours, left to right.
    localparam logic [RGB_W-1:0] TP_COLOURS [0:TP_BARS-1] = '{
        12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000
    };

endpackage

// File: rtl/vga_if.sv
// Pixel-stream bus between the timing generator and the overlay stages.
interface vga_if;
    import vga_pkg::*;

    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hblnk;
    logic                vblnk;
    logic                hsync;
    logic                vsync;
    logic [RGB_W-1:0]    rgb;

    modport out    (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
    modport in     (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
    modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
    modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping counter with blank/sync/last flags,
// all registered and derived from the next count so they align with the count they describe.
module vga_axis_counter #(
    parameter int unsigned ACTIVE   = 800,
    parameter int unsigned FP       = 40,
    parameter int unsigned SYNC     = 128,
    parameter int unsigned BP       = 88,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned W        = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         blnk,
    output logic         sync,
    output logic         last
);

    localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOTAL >= (2 ** W)) begin : g_param_err
        $error("vga_axis_counter: every timing parameter must be >= 1 and the total < 2**W");
    end

    logic [W-1:0] count_q, count_d;
    logic         blnk_q, blnk_d;
    logic         sync_q, sync_d;
    logic         last_q, last_d;

    always_comb begin
        count_d = count_q;
        if (step) begin
            count_d = last_q ? '0 : W'(count_q + 1'b1);
        end
        blnk_d = (count_d >= W'(ACTIVE));
        sync_d = ((count_d >= W'(SYNC_START)) && (count_d < W'(SYNC_END))) ? SYNC_POL : ~SYNC_POL;
        last_d = (count_d == W'(TOTAL - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= ~SYNC_POL;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
            last_q  <= last_d;
        end
    end

    assign count = count_q;
    assign blnk  = blnk_q;
    assign sync  = sync_q;
    assign last  = last_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the VGA draw chain: pixel/line counters, blanking, sync and frame_start.
// Optional colour-bar rgb when VGA_TIMING_TEST_PATTERN_EN is defined; otherwise rgb is 0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          H_SYNC_POL = 1'b1,
    parameter bit          V_SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_if.out   vga_out,
    output logic frame_start
);

    logic [HCOUNT_W-1:0] h_count;
    logic [VCOUNT_W-1:0] v_count;
    logic                h_blnk, h_sync, h_last;
    logic                v_blnk, v_sync, v_last;
    logic                v_step;
    logic                frame_start_q, frame_start_d;

    assign v_step = en && h_last;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .SYNC_POL(H_SYNC_POL), .W(HCOUNT_W)
    ) u_h_cnt (
        .clk(clk), .rst(rst), .step(en),
        .count(h_count), .blnk(h_blnk), .sync(h_sync), .last(h_last)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .SYNC_POL(V_SYNC_POL), .W(VCOUNT_W)
    ) u_v_cnt (
        .clk(clk), .rst(rst), .step(v_step),
        .count(v_count), .blnk(v_blnk), .sync(v_sync), .last(v_last)
    );

    // Pulse lands in the cycle whose registered counts have just wrapped to (0,0).
    always_comb begin
        frame_start_d = en && h_last && v_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start    = frame_start_q;
    assign vga_out.hcount = h_count;
    assign vga_out.vcount = v_count;
    assign vga_out.hblnk  = h_blnk;
    assign vga_out.vblnk  = v_blnk;
    assign vga_out.hsync  = h_sync;
    assign vga_out.vsync  = v_sync;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned BAR_W = ((H_ACTIVE / TP_BARS) > 0) ? (H_ACTIVE / TP_BARS) : 1;

    logic [HCOUNT_W-1:0] h_nxt;
    logic [VCOUNT_W-1:0] v_nxt;
    logic [HCOUNT_W-1:0] bar_full;
    logic [2:0]          bar;
    logic [RGB_W-1:0]    rgb_q, rgb_d;

    // Colour is computed from the next counts so it registers alongside them.
    always_comb begin
        h_nxt = h_count;
        v_nxt = v_count;
        if (en) begin
            h_nxt = h_last ? '0 : HCOUNT_W'(h_count + 1'b1);
            if (h_last) begin
                v_nxt = v_last ? '0 : VCOUNT_W'(v_count + 1'b1);
            end
        end
        bar_full = HCOUNT_W'(h_nxt / HCOUNT_W'(BAR_W));
        bar      = (bar_full > HCOUNT_W'(TP_BARS - 1)) ? 3'(TP_BARS - 1) : bar_full[2:0];
        rgb_d    = '0;
        if ((h_nxt < HCOUNT_W'(H_ACTIVE)) && (v_nxt < VCOUNT_W'(V_ACTIVE))) begin
            rgb_d = TP_COLOURS[bar];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga_out.rgb = rgb_q;
`else
    assign vga_out.rgb = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a 16x8 mode, with active-high and active-low sync instances.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic fs_p, fs_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  mh, mv;
    bit  mfs;
    int  en_since;

    vga_if vif_p ();
    vga_if vif_n ();

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_dut_p (
        .clk(clk), .rst(rst), .en(en), .vga_out(vif_p), .frame_start(fs_p)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) u_dut_n (
        .clk(clk), .rst(rst), .en(en), .vga_out(vif_n), .frame_start(fs_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h (h=%0d v=%0d)", tag, $time, obs, exp, mh, mv);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int h, input int v);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        logic [11:0] bars [0:7];
        bars = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000};
        return (h < 8 && v < 4) ? bars[h] : 12'h000;
`else
        return (h < 0 && v < 0) ? 12'hfff : 12'h000;
`endif
    endfunction

    task automatic compare_all();
        logic hs, vs;
        hs = (mh >= 10 && mh <= 12);
        vs = (mv >= 5 && mv <= 6);
        check_eq("hcount", 32'(vif_p.hcount), 32'(mh));
        check_eq("vcount", 32'(vif_p.vcount), 32'(mv));
        check_eq("hblnk", 32'(vif_p.hblnk), 32'(mh >= 8));
        check_eq("vblnk", 32'(vif_p.vblnk), 32'(mv >= 4));
        check_eq("hsync", 32'(vif_p.hsync), 32'(hs));
        check_eq("vsync", 32'(vif_p.vsync), 32'(vs));
        check_eq("rgb", 32'(vif_p.rgb), 32'(exp_rgb(mh, mv)));
        check_eq("frame_start", 32'(fs_p), 32'(mfs));
        check_eq("neg_hcount", 32'(vif_n.hcount), 32'(mh));
        check_eq("neg_vcount", 32'(vif_n.vcount), 32'(mv));
        check_eq("neg_hsync", 32'(vif_n.hsync), 32'(!hs));
        check_eq("neg_vsync", 32'(vif_n.vsync), 32'(!vs));
        check_eq("neg_frame_start", 32'(fs_n), 32'(mfs));
    endtask

    // Apply inputs for one clock, advance the model, then sample 1ns after the edge.
    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (!r) begin
            mh = 0; mv = 0; mfs = 1'b0; en_since = 0;
        end else if (e) begin
            mfs = (mh == 15 && mv == 7);
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            en_since++;
        end else begin
            mfs = 1'b0;
        end
        #1;
        compare_all();
        if (fs_p) begin
            check_eq("frame_period", 32'(en_since), 32'd128);
            en_since = 0;
        end
    endtask

    initial begin
        logic [31:0] pat;
        bit found;
        mh = 0; mv = 0; mfs = 1'b0; en_since = 0;
        rst = 1'b0;
        en  = 1'b0;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Free-running for a little over two frames
        for (int i = 0; i < 270; i++) step(1'b1, 1'b1);

        // Irregular enable: outputs hold while en=0
        pat = 32'b1001_0110_1100_0101_1001_1101_0010_0111;
        for (int i = 0; i < 600; i++) step(1'b1, pat[i % 32]);

        // Reset mid-frame at (11,5) with en=1
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (mh == 11 && mv == 5) found = 1'b1;
            else step(1'b1, 1'b1);
        end
        check_eq("reach_11_5", 32'(found), 32'd1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_eq("first_advance", 32'(vif_p.hcount), 32'd1);

        // Reset mid-frame with en=0
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 140; i++) step(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
